// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: types and constants shared by the instruction-fetch front end.
//   PC_W          - architectural PC / instruction width
//   NOP_INSTR     - instruction word used for the misaligned-fetch trap entry
//   fetch_entry_t - one buffered instruction: {instr, pc, misaligned}
//   fetch_state_e - fetch control states {BOOT, FETCH}
package rv_fetch_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t between memory responses and decode.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_push, i_data - write one entry (accepted when not full, or when full with a pop)
//   i_pop          - consume the head entry (ignored when empty)
//   i_flush        - discard all entries
//   o_head         - head entry, driven straight from storage registers
//   o_count        - number of stored entries
//   o_full/o_empty - occupancy flags
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end owning the architectural PC.
// Issues sequential fetches over a valid/ready request channel (in-order responses),
// buffers instructions with their PC toward decode, and handles taken-branch redirects
// by flushing the buffer and squashing every fetch still in flight.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     - taken branch/jump and its target
//   imem_req_valid/ready/addr       - fetch request channel
//   imem_rsp_valid, imem_rsp_data   - in-order fetch responses (never stall)
//   if_valid/ready, if_instr, if_pc - buffered instruction toward decode
//   if_misaligned                   - only with FETCH_MISALIGN_TRAP_EN: head entry is a
//                                     misaligned-target trap marker
// Build option FETCH_MISALIGN_TRAP_EN: a redirect to a non word-aligned target halts
// fetching and delivers a single NOP entry flagged misaligned; without it the low two
// target bits are treated as zero.
module pc_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        if_misaligned,
`endif
    output logic [31:0] if_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 2;
    localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_pc;        // next fetch address
    logic [31:0]   r_rsp_pc;    // PC of the next live response
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_kill;
    logic [CW-1:0] w_live_nxt;
    logic [CW-1:0] w_kill_nxt;
    logic [31:0]   w_red_pc;
    logic          w_halt;
    logic          w_trap_push;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_rsp;
    logic          w_rsp_kill;
    logic          w_rsp_live;
    logic          w_push;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;
    logic [FW-1:0] w_count;
    logic          w_full;
    logic          w_empty;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_halt;
    logic r_trap_pend;

    assign w_red_pc    = redirect_pc;
    assign w_halt      = r_halt;
    // Trap entry goes in the cycle after the redirect, once the flush has emptied the buffer.
    assign w_trap_push = r_trap_pend && !redirect_valid;
    assign if_misaligned = w_head.misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt      <= 1'b0;
            r_trap_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_halt      <= |redirect_pc[1:0];
            r_trap_pend <= |redirect_pc[1:0];
        end else begin
            r_trap_pend <= 1'b0;
        end
    end
`else
    assign w_red_pc    = redirect_pc & 32'hFFFF_FFFC;
    assign w_halt      = 1'b0;
    assign w_trap_push = 1'b0;

    always_ff @(posedge clk) begin
        if (rst_n && if_valid) begin
            assert (!w_head.misaligned);
        end
    end
`endif

    // Credit: live fetches plus buffered entries never exceed the buffer size.
    assign w_credit   = (r_live + CW'(w_count)) < CW'(FIFO_DEPTH);
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp      = imem_rsp_valid && (r_state == FETCH);
    assign w_rsp_kill = w_rsp && (r_kill != '0);
    assign w_rsp_live = w_rsp && (r_kill == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        case (r_state)
            BOOT:    w_state_nxt = FETCH;
            FETCH:   imem_req_valid = w_credit && !redirect_valid && !w_halt;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_comb begin
        w_live_nxt = r_live;
        w_kill_nxt = r_kill;
        if (redirect_valid) begin
            // Everything still outstanding, minus a response retiring now, becomes stale.
            w_live_nxt = '0;
            w_kill_nxt = r_kill + r_live + CW'(w_req_fire) - CW'(w_rsp);
        end else begin
            w_live_nxt = r_live + CW'(w_req_fire) - CW'(w_rsp_live);
            w_kill_nxt = r_kill - CW'(w_rsp_kill);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_live   <= '0;
            r_kill   <= '0;
        end else begin
            r_live <= w_live_nxt;
            r_kill <= w_kill_nxt;
            if (redirect_valid) begin
                r_pc     <= w_red_pc;
                r_rsp_pc <= w_red_pc;
            end else begin
                if (w_req_fire) r_pc     <= r_pc + 32'd4;
                if (w_rsp_live) r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    assign imem_req_addr = r_pc;

    // While halted r_pc still holds the misaligned target, which is the trap entry's PC.
    assign w_push = (w_rsp_live && !redirect_valid) || w_trap_push;
    always_comb begin
        w_push_data = '{instr: imem_rsp_data, pc: r_rsp_pc, misaligned: 1'b0};
        if (w_trap_push) begin
            w_push_data = '{instr: NOP_INSTR, pc: r_pc, misaligned: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && w_full && !if_ready));
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (if_ready),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign if_valid = !w_empty;
    assign if_instr = w_head.instr;
    assign if_pc    = w_head.pc;

endmodule
